add_sub_alu: RTL

//  Parametrised, handshaked successor to the 4-bit add/subtract unit: WIDTH-bit ALU with
//  8 opcodes, registered result and optional status flags. Sits on the Prathama datapath
//  bus; the sequencer raises cs when rdy=1 and collects the result on the valid pulse.

---
 rtl/add_sub_alu_pkg.sv | 21 ++
 rtl/add_sub_alu_if.sv | 32 +++
 rtl/add_sub_alu_core.sv | 61 ++++++
 rtl/add_sub_alu.sv | 112 +++++++++++
 4 files changed

// File: rtl/add_sub_alu_pkg.sv
// add_sub_alu_pkg: opcode and FSM state encodings shared by the ALU top, its core and users.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package add_sub_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_DEC = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_sub_alu_if.sv
// add_sub_alu_if: request/result bundle between the datapath sequencer (master) and the ALU (slave).
// Latency: n/a (wires only).
// Backpressure: master may raise cs only while rdy=1; results are qualified by the 1-cycle valid pulse.
// Signals: cs, OP, A, B, CIN (master->slave); SUM, COUT, rdy, valid, ZF, NF, VF (slave->master).
interface add_sub_alu_if #(
  parameter int WIDTH = 8
) ();

  logic             cs;
  logic [2:0]       OP;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic             rdy;
  logic             valid;
  logic             ZF;
  logic             NF;
  logic             VF;

  modport master (
    output cs, OP, A, B, CIN,
    input  SUM, COUT, rdy, valid, ZF, NF, VF
  );

  modport slave (
    input  cs, OP, A, B, CIN,
    output SUM, COUT, rdy, valid, ZF, NF, VF
  );

endinterface

// File: rtl/add_sub_alu_core.sv
// add_sub_alu_core: combinational WIDTH-bit datapath (op,a,b,cin) -> (res,cout,zf,nf,vf).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller registers the outputs.
// Ports: op/a/b/cin in; res/cout/zf/nf/vf out. Flags are only built with ADD_SUB_ALU_FLAGS_EN, else tied 0.
module add_sub_alu_core #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             zf,
  output logic             nf,
  output logic             vf
);
  import add_sub_alu_pkg::*;

  // All four arithmetic ops share one adder: a + b_eff + c_eff.
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH:0]   sum_ext;

  always_comb begin
    b_eff = '0;
    c_eff = 1'b0;
    case (op)
      OP_ADD:  begin b_eff = b;  c_eff = cin;  end
      OP_SUB:  begin b_eff = ~b; c_eff = 1'b1; end
      OP_INC:  begin b_eff = {{(WIDTH-1){1'b0}}, 1'b1}; end
      OP_DEC:  begin b_eff = '1; end
      default: ;
    endcase
    sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
  end

  always_comb begin
    res  = '0;
    cout = 1'b0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      default: {cout, res} = sum_ext;
    endcase
  end

`ifdef ADD_SUB_ALU_FLAGS_EN
  // Arithmetic opcodes (000,001,110,111) are exactly those with op[2]==op[1].
  assign zf = (res == '0);
  assign nf = res[WIDTH-1];
  assign vf = (op[2] == op[1]) && (a[WIDTH-1] == b_eff[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
`else
  assign zf = 1'b0;
  assign nf = 1'b0;
  assign vf = 1'b0;
`endif

endmodule

// File: rtl/add_sub_alu.sv
// add_sub_alu: handshaked WIDTH-bit ALU (8 opcodes) with registered result and optional ZF/NF/VF flags.
// Latency: cs captured at edge k, result registered at edge k+1 (valid high), idle again at edge k+2.
// Backpressure: cs honoured only while rdy=1 (IDLE); requests during EXEC/DONE are dropped, not queued.
// Ports: clk, rst (sync active-high), bus (add_sub_alu_if.slave). Optional macro: ADD_SUB_ALU_FLAGS_EN.
module add_sub_alu #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  add_sub_alu_if.slave  bus
);
  import add_sub_alu_pkg::*;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic [WIDTH-1:0] res_c;
  logic             cout_c, zf_c, nf_c, vf_c;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    bus.rdy   = 1'b0;
    bus.valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.rdy = 1'b1;
        if (bus.cs) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: begin
        bus.valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands are frozen at the capture edge so the bus may change freely afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else if (state_q == ST_IDLE && bus.cs) begin
      op_q  <= bus.OP;
      a_q   <= bus.A;
      b_q   <= bus.B;
      cin_q <= bus.CIN;
    end
  end

  add_sub_alu_core #(.WIDTH(WIDTH)) u_core (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .cin  (cin_q),
    .res  (res_c),
    .cout (cout_c),
    .zf   (zf_c),
    .nf   (nf_c),
    .vf   (vf_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      sum_q  <= res_c;
      cout_q <= cout_c;
    end
  end

  assign bus.SUM  = sum_q;
  assign bus.COUT = cout_q;

`ifdef ADD_SUB_ALU_FLAGS_EN
  logic zf_q, nf_q, vf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b0;
      nf_q <= 1'b0;
      vf_q <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      zf_q <= zf_c;
      nf_q <= nf_c;
      vf_q <= vf_c;
    end
  end

  assign bus.ZF = zf_q;
  assign bus.NF = nf_q;
  assign bus.VF = vf_q;
`else
  // Core ties its flag outputs to 0 in this build; no flag registers exist.
  assign bus.ZF = zf_c;
  assign bus.NF = nf_c;
  assign bus.VF = vf_c;
`endif

endmodule
